// File: rtl/cpu_ctrl_pkg.sv
// Shared control-sequencer definitions: step states, ALU opcode map,
// opcode classification and IR field placement helpers.
package cpu_ctrl_pkg;

   localparam int OPC_BITS = 5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T0   = 3'd1,
      ST_T1   = 3'd2,
      ST_T2   = 3'd3,
      ST_T3   = 3'd4,
      ST_T4   = 3'd5,
      ST_T5   = 3'd6,
      ST_T6   = 3'd7
   } state_t;

   localparam logic [OPC_BITS-1:0] OP_ADD = 5'b00011;
   localparam logic [OPC_BITS-1:0] OP_SUB = 5'b00100;
   localparam logic [OPC_BITS-1:0] OP_AND = 5'b00101;
   localparam logic [OPC_BITS-1:0] OP_OR  = 5'b00110;
   localparam logic [OPC_BITS-1:0] OP_SHR = 5'b00111;
   localparam logic [OPC_BITS-1:0] OP_SHL = 5'b01000;
   localparam logic [OPC_BITS-1:0] OP_ROR = 5'b01001;
   localparam logic [OPC_BITS-1:0] OP_ROL = 5'b01010;
   localparam logic [OPC_BITS-1:0] OP_MUL = 5'b01111;
   localparam logic [OPC_BITS-1:0] OP_DIV = 5'b10000;
   localparam logic [OPC_BITS-1:0] OP_NEG = 5'b10001;
   localparam logic [OPC_BITS-1:0] OP_NOT = 5'b10010;

   typedef struct packed {
      logic legal;
      logic unary;
      logic muldiv;
   } op_class_t;

   function automatic op_class_t classify_op(input logic [OPC_BITS-1:0] opc);
      op_class_t c;
      c = '0;
      case (opc)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: c.legal = 1'b1;
         OP_MUL, OP_DIV: begin
            c.legal  = 1'b1;
            c.muldiv = 1'b1;
         end
         OP_NEG, OP_NOT: begin
            c.legal = 1'b1;
            c.unary = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Register fields sit directly below the opcode: Ra, then Rb, then Rc.
   function automatic int ir_ra_lsb(input int data_w, input int opc_w, input int raddr_w);
      return data_w - opc_w - raddr_w;
   endfunction

   function automatic int ir_rb_lsb(input int data_w, input int opc_w, input int raddr_w);
      return data_w - opc_w - 2 * raddr_w;
   endfunction

   function automatic int ir_rc_lsb(input int data_w, input int opc_w, input int raddr_w);
      return data_w - opc_w - 3 * raddr_w;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_reg_select_decoder.sv
// Register-address to one-hot select decoder; all-zero when not enabled
// or when the address has no matching register.
module reg_select_decoder #(
   parameter int RADDR_W  = 4,
   parameter int NUM_REGS = 16
) (
   input  logic [RADDR_W-1:0]  addr,
   input  logic                en,
   output logic [NUM_REGS-1:0] sel
);

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (addr == RADDR_W'(i))) begin
            sel[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Fetch/decode/execute control-step sequencer for register-register ALU
// instructions; drives every datapath strobe from the registered step state.
module alu_op_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int OPC_W    = 5,
   parameter int RADDR_W  = 4,
   parameter int NUM_REGS = 16
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                Run,
   input  logic                Stop,
   input  logic [DATA_W-1:0]   IR_data,
   input  logic                Mem_ready,
   output logic                PCout,
   output logic                MARin,
   output logic                IncPC,
   output logic                Zin,
   output logic                PCin,
   output logic                Read,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic                Zlowout,
   output logic                Zhighout,
   output logic                LOin,
   output logic                HIin,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic [OPC_W-1:0]    operation,
   output logic                Busy,
   output logic                Done,
   output logic                Illegal,
   output logic [2:0]          state_dbg
);

   localparam int RA_LSB = ir_ra_lsb(DATA_W, OPC_W, RADDR_W);
   localparam int RB_LSB = ir_rb_lsb(DATA_W, OPC_W, RADDR_W);
   localparam int RC_LSB = ir_rc_lsb(DATA_W, OPC_W, RADDR_W);
   localparam logic [RADDR_W:0] NREGS_L = (RADDR_W + 1)'(NUM_REGS);

   state_t state, state_nx;
   logic   stop_seen;

   logic [OPC_W-1:0]   opc;
   logic [RADDR_W-1:0] ra, rb, rc;
   op_class_t          op_cls;
   logic               range_bad;
   logic               illegal_op;
   state_t             end_state;

   logic               rin_en, rout_en;
   logic [RADDR_W-1:0] rin_addr, rout_addr;
   logic               unused_ir;

   // IR fields are only meaningful from T3 onward; earlier steps ignore them.
   assign opc       = IR_data[DATA_W-1 -: OPC_W];
   assign ra        = IR_data[RA_LSB +: RADDR_W];
   assign rb        = IR_data[RB_LSB +: RADDR_W];
   assign rc        = IR_data[RC_LSB +: RADDR_W];
   assign unused_ir = ^IR_data[RC_LSB-1:0];

   assign op_cls     = classify_op(OPC_BITS'(opc));
   assign range_bad  = ({1'b0, ra} >= NREGS_L) || ({1'b0, rb} >= NREGS_L) ||
                       (!op_cls.unary && ({1'b0, rc} >= NREGS_L));
   assign illegal_op = !op_cls.legal || range_bad;

   // A Stop seen at any step of the instruction, including its last one,
   // sends the sequencer to IDLE instead of the next fetch.
   assign end_state = (stop_seen || Stop) ? ST_IDLE : ST_T0;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= ST_IDLE;
         stop_seen <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE) begin
            stop_seen <= 1'b0;
         end else if (Stop) begin
            stop_seen <= 1'b1;
         end
      end
   end

   // Memory handshake: T1 issues Read/MDRin and holds every strobe until the
   // cycle Mem_ready is high, which is the cycle MDR captures the read data.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (Run && !Stop) state_nx = ST_T0;
         ST_T0:   state_nx = ST_T1;
         ST_T1:   if (Mem_ready) state_nx = ST_T2;
         ST_T2:   state_nx = ST_T3;
         ST_T3: begin
            if (illegal_op)        state_nx = end_state;
            else if (op_cls.unary) state_nx = ST_T5;
            else                   state_nx = ST_T4;
         end
         ST_T4:   state_nx = ST_T5;
         ST_T5:   state_nx = op_cls.muldiv ? ST_T6 : end_state;
         ST_T6:   state_nx = end_state;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      PCout     = 1'b0;
      MARin     = 1'b0;
      IncPC     = 1'b0;
      Zin       = 1'b0;
      PCin      = 1'b0;
      Read      = 1'b0;
      MDRin     = 1'b0;
      MDRout    = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      Zlowout   = 1'b0;
      Zhighout  = 1'b0;
      LOin      = 1'b0;
      HIin      = 1'b0;
      operation = '0;
      Done      = 1'b0;
      Illegal   = 1'b0;
      rin_en    = 1'b0;
      rin_addr  = ra;
      rout_en   = 1'b0;
      rout_addr = rb;
      case (state)
         ST_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         ST_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            if (illegal_op) begin
               Illegal = 1'b1;
            end else if (op_cls.unary) begin
               rout_en   = 1'b1;
               Zin       = 1'b1;
               operation = opc;
            end else begin
               rout_en = 1'b1;
               Yin     = 1'b1;
            end
         end
         ST_T4: begin
            rout_en   = 1'b1;
            rout_addr = rc;
            Zin       = 1'b1;
            operation = opc;
         end
         ST_T5: begin
            Zlowout = 1'b1;
            if (op_cls.muldiv) begin
               LOin = 1'b1;
            end else begin
               rin_en = 1'b1;
               Done   = 1'b1;
            end
         end
         ST_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
            Done     = 1'b1;
         end
         default: ;
      endcase
   end

   assign Busy      = (state != ST_IDLE);
   assign state_dbg = state;

   reg_select_decoder #(
      .RADDR_W  (RADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rin_dec (
      .addr (rin_addr),
      .en   (rin_en),
      .sel  (Rin)
   );

   reg_select_decoder #(
      .RADDR_W  (RADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rout_dec (
      .addr (rout_addr),
      .en   (rout_en),
      .sel  (Rout)
   );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural bus datapath driven by the DUT
// strobes, directed instructions, and a scoreboard checked on Done/Illegal.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

   localparam int NUM_REGS = 16;
   localparam logic [4:0] C_ADD = 5'b00011;
   localparam logic [4:0] C_SUB = 5'b00100;
   localparam logic [4:0] C_AND = 5'b00101;
   localparam logic [4:0] C_OR  = 5'b00110;
   localparam logic [4:0] C_SHR = 5'b00111;
   localparam logic [4:0] C_SHL = 5'b01000;
   localparam logic [4:0] C_ROR = 5'b01001;
   localparam logic [4:0] C_ROL = 5'b01010;
   localparam logic [4:0] C_MUL = 5'b01111;
   localparam logic [4:0] C_DIV = 5'b10000;
   localparam logic [4:0] C_NEG = 5'b10001;
   localparam logic [4:0] C_NOT = 5'b10010;
   localparam logic [4:0] C_BAD = 5'b11111;

   logic Clock, Reset_n, Run, Stop, Mem_ready;
   logic [31:0] IR_data;
   logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
   logic Zlowout, Zhighout, LOin, HIin;
   logic [NUM_REGS-1:0] Rin, Rout;
   logic [4:0] operation;
   logic Busy, Done, Illegal;
   logic [2:0] state_dbg;

   typedef struct {
      bit          illegal;
      int          latency;
      int          t1;
      bit          chk_reg;
      int          ridx;
      logic [31:0] rval;
      bit          chk_hilo;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t exp_q[$];
   int checks;
   int failures;
   int wait_cfg;

   logic        pre_we;
   int          pre_kind;
   int          pre_idx;
   logic [31:0] pre_val;

   alu_op_sequencer dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .Run       (Run),
      .Stop      (Stop),
      .IR_data   (IR_data),
      .Mem_ready (Mem_ready),
      .PCout     (PCout),
      .MARin     (MARin),
      .IncPC     (IncPC),
      .Zin       (Zin),
      .PCin      (PCin),
      .Read      (Read),
      .MDRin     (MDRin),
      .MDRout    (MDRout),
      .IRin      (IRin),
      .Yin       (Yin),
      .Zlowout   (Zlowout),
      .Zhighout  (Zhighout),
      .LOin      (LOin),
      .HIin      (HIin),
      .Rin       (Rin),
      .Rout      (Rout),
      .operation (operation),
      .Busy      (Busy),
      .Done      (Done),
      .Illegal   (Illegal),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // ---------------- datapath model ----------------
   logic [31:0] regs [NUM_REGS];
   logic [31:0] mem  [64];
   logic [31:0] pc, mar, mdr, ir, y, hi, lo;
   logic [63:0] z, alu, rot;
   logic [31:0] bus;

   assign IR_data = ir;

   always_comb begin
      bus = '0;
      if (PCout)    bus = pc;
      if (MDRout)   bus = mdr;
      if (Zlowout)  bus = z[31:0];
      if (Zhighout) bus = z[63:32];
      for (int i = 0; i < NUM_REGS; i++) begin
         if (Rout[i]) bus = regs[i];
      end
   end

   always_comb begin
      alu = '0;
      rot = '0;
      case (operation)
         C_ADD: alu = {32'b0, y + bus};
         C_SUB: alu = {32'b0, y - bus};
         C_AND: alu = {32'b0, y & bus};
         C_OR:  alu = {32'b0, y | bus};
         C_SHR: alu = {32'b0, y >> bus[4:0]};
         C_SHL: alu = {32'b0, y << bus[4:0]};
         C_ROR: begin
            rot = {y, y} >> bus[4:0];
            alu = {32'b0, rot[31:0]};
         end
         C_ROL: begin
            rot = {y, y} << bus[4:0];
            alu = {32'b0, rot[63:32]};
         end
         C_MUL: alu = {32'b0, y} * {32'b0, bus};
         C_DIV: if (bus != 0) alu = {y % bus, y / bus};
         C_NEG: alu = {32'b0, -bus};
         C_NOT: alu = {32'b0, ~bus};
         default: if (IncPC) alu = {32'b0, bus + 32'd1};
      endcase
   end

   always @(posedge Clock) begin
      if (pre_we) begin
         case (pre_kind)
            0:       regs[pre_idx[3:0]] <= pre_val;
            1:       mem[pre_idx[5:0]]  <= pre_val;
            default: pc                 <= pre_val;
         endcase
      end
      if (MARin) mar <= bus;
      if (Zin)   z   <= alu;
      if (PCin)  pc  <= bus;
      if (MDRin && Read && Mem_ready) mdr <= mem[mar[5:0]];
      if (IRin)  ir  <= bus;
      if (Yin)   y   <= bus;
      if (LOin)  lo  <= bus;
      if (HIin)  hi  <= bus;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (Rin[i]) regs[i] <= bus;
      end
   end

   // Memory responder: stalls the first wait_cfg T1 cycles of each fetch.
   initial begin
      int wl;
      wl = 0;
      Mem_ready = 1'b1;
      forever begin
         @(negedge Clock);
         if (PCout) wl = wait_cfg;
         if (Read && wl > 0) begin
            Mem_ready = 1'b0;
            wl--;
         end else begin
            Mem_ready = 1'b1;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] enc(input logic [4:0] opc, input int ra, input int rb, input int rc);
      return {opc, 4'(ra), 4'(rb), 4'(rc), 15'b0};
   endfunction

   task automatic preload(input int kind, input int idx, input logic [31:0] val);
      @(negedge Clock);
      pre_we   = 1'b1;
      pre_kind = kind;
      pre_idx  = idx;
      pre_val  = val;
      @(negedge Clock);
      pre_we   = 1'b0;
   endtask

   task automatic push_exp(input bit ill, input int lat, input int t1, input bit cr,
                           input int ridx, input logic [31:0] rv, input bit ch,
                           input logic [31:0] h, input logic [31:0] l);
      exp_t e;
      e.illegal  = ill;
      e.latency  = lat;
      e.t1       = t1;
      e.chk_reg  = cr;
      e.ridx     = ridx;
      e.rval     = rv;
      e.chk_hilo = ch;
      e.hi       = h;
      e.lo       = l;
      exp_q.push_back(e);
   endtask

   // Runs n instructions from the preloaded PC; Stop is raised in the T2 of the last one.
   task automatic run_prog(input int n, input int wcfg);
      int  t2s;
      bit  seen_busy;
      bit  finished;
      t2s       = 0;
      seen_busy = 1'b0;
      finished  = 1'b0;
      wait_cfg  = wcfg;
      @(negedge Clock);
      Run = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge Clock);
         if (Busy) Run = 1'b0;
         if (Stop) begin
            Stop = 1'b0;
         end else if (MDRout && IRin) begin
            t2s++;
            if (t2s == n) Stop = 1'b1;
         end
         if (seen_busy && !Busy && !Stop) begin
            finished = 1'b1;
            break;
         end
         if (Busy) seen_busy = 1'b1;
      end
      Run  = 1'b0;
      Stop = 1'b0;
      chk("run_timeout", {63'b0, finished}, 64'd1);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      int   cyc, start, t1;
      bit   pend;
      exp_t e, pe;
      cyc   = 0;
      start = 0;
      t1    = 0;
      pend  = 1'b0;
      forever begin
         @(negedge Clock);
         cyc++;
         if (pend) begin
            pend = 1'b0;
            if (pe.chk_reg) chk("result_reg", {32'b0, regs[pe.ridx]}, {32'b0, pe.rval});
            if (pe.chk_hilo) begin
               chk("result_hi", {32'b0, hi}, {32'b0, pe.hi});
               chk("result_lo", {32'b0, lo}, {32'b0, pe.lo});
            end
         end
         if (Reset_n) begin
            chk("one_bus_driver",
                64'(int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout) + int'(|Rout) <= 1), 64'd1);
            chk("rin_onehot0", {63'b0, $onehot0(Rin)}, 64'd1);
            chk("rout_onehot0", {63'b0, $onehot0(Rout)}, 64'd1);
            chk("op_zero_without_zin", {63'b0, (operation == 5'd0) || Zin}, 64'd1);
            chk("illegal_no_strobes", {63'b0, Illegal && ((|Rin) || (|Rout) || Yin || Zin)}, 64'd0);
            chk("done_not_with_loin", {63'b0, Done && (LOin || Illegal)}, 64'd0);
         end
         if (PCout && MARin) begin
            start = cyc;
            t1    = 0;
         end
         if (Read) t1++;
         if (Done || Illegal) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_end_pulse", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("end_is_illegal", {63'b0, Illegal}, {63'b0, e.illegal});
               chk("latency", 64'(cyc - start + 1), 64'(e.latency));
               chk("t1_cycles", 64'(t1), 64'(e.t1));
               pe   = e;
               pend = 1'b1;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      logic [63:0] outs;
      bit          hit;
      checks   = 0;
      failures = 0;
      Run      = 1'b0;
      Stop     = 1'b0;
      pre_we   = 1'b0;
      pre_kind = 0;
      pre_idx  = 0;
      pre_val  = '0;
      wait_cfg = 0;
      Reset_n  = 1'b0;
      repeat (3) @(negedge Clock);
      outs = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
              Zlowout, Zhighout, LOin, HIin, Rin, Rout, operation, Busy, Done, Illegal, state_dbg};
      chk("reset_outputs", outs, 64'd0);
      Reset_n = 1'b1;

      preload(1, 0, enc(C_OR,  4, 3, 7));
      preload(1, 1, enc(C_MUL, 1, 2, 3));
      preload(1, 2, enc(C_NOT, 5, 6, 0));
      preload(1, 3, enc(C_BAD, 1, 2, 3));
      preload(1, 4, enc(C_DIV, 1, 2, 3));
      preload(1, 5, enc(C_NEG, 11, 12, 0));
      preload(1, 6, enc(C_SHL, 0, 1, 2));
      preload(1, 7, enc(C_ROR, 13, 14, 15));
      preload(1, 32, enc(C_ADD, 2, 2, 2));
      preload(1, 33, enc(C_SUB, 8, 9, 10));

      // Reset asserted mid-instruction (T4), between clock edges.
      preload(0, 3, 32'h22);
      preload(0, 7, 32'h24);
      preload(2, 0, 32'd0);
      wait_cfg = 0;
      hit = 1'b0;
      @(negedge Clock);
      Run = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge Clock);
         if (Busy) Run = 1'b0;
         if (Zin && (|Rout) && !Yin) begin
            hit = 1'b1;
            break;
         end
      end
      Run = 1'b0;
      chk("reach_t4", {63'b0, hit}, 64'd1);
      #2 Reset_n = 1'b0;
      #1;
      outs = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
              Zlowout, Zhighout, LOin, HIin, Rin, Rout, operation, Busy, Done, Illegal, state_dbg};
      chk("async_reset_outputs", outs, 64'd0);
      @(negedge Clock);
      Reset_n = 1'b1;
      @(negedge Clock);
      chk("post_reset_busy", {63'b0, Busy}, 64'd0);
      chk("post_reset_state", {61'b0, state_dbg}, 64'd0);

      // Run and Stop together in IDLE: no fetch.
      @(negedge Clock);
      Run  = 1'b1;
      Stop = 1'b1;
      repeat (3) @(negedge Clock);
      chk("run_stop_stays_idle", {63'b0, Busy}, 64'd0);
      Run  = 1'b0;
      Stop = 1'b0;

      // OR R4,R3,R7: 0x22 | 0x24 = 0x26, 6 cycles.
      preload(0, 4, 32'h0);
      preload(2, 0, 32'd0);
      push_exp(0, 6, 1, 1, 4, 32'h26, 0, 0, 0);
      run_prog(1, 0);

      // Same with 3 memory wait cycles: T1 held 4 cycles, 9 total.
      preload(0, 4, 32'h0);
      preload(2, 0, 32'd0);
      push_exp(0, 9, 4, 1, 4, 32'h26, 0, 0, 0);
      run_prog(1, 3);

      // MUL R1,R2,R3: 0x10000 * 0x10000 = 0x1_0000_0000 -> HI=1, LO=0.
      preload(0, 2, 32'h10000);
      preload(0, 3, 32'h10000);
      preload(2, 0, 32'd1);
      push_exp(0, 7, 1, 0, 0, 0, 1, 32'h1, 32'h0);
      run_prog(1, 0);

      // NOT R5,R6 with R6=0.
      preload(0, 6, 32'h0);
      preload(2, 0, 32'd2);
      push_exp(0, 5, 1, 1, 5, 32'hFFFF_FFFF, 0, 0, 0);
      run_prog(1, 0);

      // Undefined opcode: Illegal pulse in T3 (cycle 4).
      preload(2, 0, 32'd3);
      push_exp(1, 4, 1, 0, 0, 0, 0, 0, 0);
      run_prog(1, 0);

      // DIV R1,R2,R3: 17/5 -> LO=3, HI=2.
      preload(0, 2, 32'd17);
      preload(0, 3, 32'd5);
      preload(2, 0, 32'd4);
      push_exp(0, 7, 1, 0, 0, 0, 1, 32'd2, 32'd3);
      run_prog(1, 0);

      // NEG R11,R12 with R12=1.
      preload(0, 12, 32'd1);
      preload(2, 0, 32'd5);
      push_exp(0, 5, 1, 1, 11, 32'hFFFF_FFFF, 0, 0, 0);
      run_prog(1, 0);

      // SHL R0,R1,R2: 1 << 4.
      preload(0, 1, 32'd1);
      preload(0, 2, 32'd4);
      preload(2, 0, 32'd6);
      push_exp(0, 6, 1, 1, 0, 32'h10, 0, 0, 0);
      run_prog(1, 0);

      // ROR R13,R14,R15: 1 rotated right by 1.
      preload(0, 14, 32'd1);
      preload(0, 15, 32'd1);
      preload(2, 0, 32'd7);
      push_exp(0, 6, 1, 1, 13, 32'h8000_0000, 0, 0, 0);
      run_prog(1, 0);

      // Back-to-back: ADD R2,R2,R2 (5+5) then SUB R8,R9,R10 (3-5), Stop in the second.
      preload(0, 2, 32'd5);
      preload(0, 9, 32'd3);
      preload(0, 10, 32'd5);
      preload(2, 0, 32'd32);
      push_exp(0, 6, 1, 1, 2, 32'hA, 0, 0, 0);
      push_exp(0, 6, 1, 1, 8, 32'hFFFF_FFFE, 0, 0, 0);
      run_prog(2, 0);

      repeat (4) @(negedge Clock);
      chk("idle_after_stop", {63'b0, Busy}, 64'd0);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
